cgra_kernel_launcher: RTL and testbench

Host-side initiator for the CGRA kernel start/done handshake. Drives `Computation_Start` into the CGRA top level and monitors `Computation_Done`, running a full four-phase handshake for each of N back-to-back kernel invocations. Reports busy, completion, per-batch cycle count and timeout errors to the controlling processor logic. Sits between the processor register file and the CGRA top.

---
 rtl/cgra_ctrl_pkg.sv | 18 +
 rtl/sync2.sv | 25 ++
 rtl/cgra_kernel_launcher.sv | 150 +++++++++++++++
 tb/tb_cgra_kernel_launcher.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cgra_ctrl_pkg.sv
// Shared definitions for the CGRA host-side control blocks.
//   launch_state_e : kernel launcher FSM encoding
//   CWIDTH_DEF     : default cycle counter / timeout width
//   NWIDTH_DEF     : default iteration count width
package cgra_ctrl_pkg;

    localparam int CWIDTH_DEF = 32;
    localparam int NWIDTH_DEF = 16;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PRECHECK = 3'd1,
        ST_ASSERT   = 3'd2,
        ST_RELEASE  = 3'd3,
        ST_FINISH   = 3'd4
    } launch_state_e;

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous status bit.
//   clk   : destination clock
//   rst_n : asynchronous active-low reset, clears both flops
//   d     : asynchronous input
//   q     : synchronized output (two destination cycles of latency)
module sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/cgra_kernel_launcher.sv
// Host-side initiator for the CGRA start/done four-phase handshake.
// Runs Iter_Count back-to-back kernel invocations per accepted launch.
//   Clk, Resetn        : clock, asynchronous active-low reset
//   Launch_Req         : one-cycle batch request (ignored while Busy)
//   Abort              : level, cancels the running batch
//   Iter_Count         : invocations per batch, sampled at launch
//   Timeout_Cycles     : per-phase timeout, 0 disables, sampled at launch
//   Computation_Start  : handshake request to the CGRA
//   Computation_Done   : handshake acknowledge from the CGRA (asynchronous)
//   Busy, Launch_Done  : batch in progress / one-cycle end-of-batch pulse
//   Error              : sticky timeout/abort flag, cleared on next launch
//   Iter_Done          : invocations completed in current/last batch
//   Cycle_Count        : Busy cycles in current/last batch, saturating
module cgra_kernel_launcher
    import cgra_ctrl_pkg::*;
#(
    parameter int CWIDTH = CWIDTH_DEF,
    parameter int NWIDTH = NWIDTH_DEF
) (
    input  logic              Clk,
    input  logic              Resetn,
    input  logic              Launch_Req,
    input  logic              Abort,
    input  logic [NWIDTH-1:0] Iter_Count,
    input  logic [CWIDTH-1:0] Timeout_Cycles,
    output logic              Computation_Start,
    input  logic              Computation_Done,
    output logic              Busy,
    output logic              Launch_Done,
    output logic              Error,
    output logic [NWIDTH-1:0] Iter_Done,
    output logic [CWIDTH-1:0] Cycle_Count
);

    launch_state_e     state;
    logic [NWIDTH-1:0] iter_lat;
    logic [CWIDTH-1:0] tmo_lat;
    logic [CWIDTH-1:0] phase_tmr;
    logic [NWIDTH-1:0] iter_inc;
    logic              done_s;
    logic              in_phase;
    logic              tmo_hit;
    logic              phase_kill;

    sync2 u_done_sync (
        .clk   (Clk),
        .rst_n (Resetn),
        .d     (Computation_Done),
        .q     (done_s)
    );

    assign in_phase   = (state == ST_PRECHECK) || (state == ST_ASSERT) ||
                        (state == ST_RELEASE);
    // phase_tmr counts cycles already spent in the current state, so the
    // timeout fires on the edge that completes the tmo_lat-th cycle.
    assign tmo_hit    = (tmo_lat != '0) && (phase_tmr == tmo_lat - CWIDTH'(1));
    assign phase_kill = in_phase && (Abort || tmo_hit);
    assign iter_inc   = Iter_Done + NWIDTH'(1);

    always_ff @(posedge Clk or negedge Resetn) begin
        if (!Resetn) begin
            state             <= ST_IDLE;
            iter_lat          <= '0;
            tmo_lat           <= '0;
            phase_tmr         <= '0;
            Computation_Start <= 1'b0;
            Busy              <= 1'b0;
            Launch_Done       <= 1'b0;
            Error             <= 1'b0;
            Iter_Done         <= '0;
            Cycle_Count       <= '0;
        end else begin
            Launch_Done <= 1'b0;
            if (Busy && (Cycle_Count != '1))
                Cycle_Count <= Cycle_Count + CWIDTH'(1);

            if (phase_kill) begin
                Error             <= 1'b1;
                Computation_Start <= 1'b0;
                Launch_Done       <= 1'b1;
                state             <= ST_FINISH;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (Launch_Req) begin
                            iter_lat    <= Iter_Count;
                            tmo_lat     <= Timeout_Cycles;
                            Iter_Done   <= '0;
                            Cycle_Count <= '0;
                            Error       <= 1'b0;
                            Busy        <= 1'b1;
                            phase_tmr   <= '0;
                            if (Iter_Count == '0) begin
                                Launch_Done <= 1'b1;
                                state       <= ST_FINISH;
                            end else begin
                                state <= ST_PRECHECK;
                            end
                        end
                    end
                    // Stale Done from a previous run must clear before the
                    // first request, or it would read as an instant ack.
                    ST_PRECHECK: begin
                        if (!done_s) begin
                            Computation_Start <= 1'b1;
                            phase_tmr         <= '0;
                            state             <= ST_ASSERT;
                        end else begin
                            phase_tmr <= phase_tmr + CWIDTH'(1);
                        end
                    end
                    ST_ASSERT: begin
                        if (done_s) begin
                            Computation_Start <= 1'b0;
                            phase_tmr         <= '0;
                            state             <= ST_RELEASE;
                        end else begin
                            phase_tmr <= phase_tmr + CWIDTH'(1);
                        end
                    end
                    ST_RELEASE: begin
                        if (!done_s) begin
                            Iter_Done <= iter_inc;
                            phase_tmr <= '0;
                            if (iter_inc == iter_lat) begin
                                Launch_Done <= 1'b1;
                                state       <= ST_FINISH;
                            end else begin
                                Computation_Start <= 1'b1;
                                state             <= ST_ASSERT;
                            end
                        end else begin
                            phase_tmr <= phase_tmr + CWIDTH'(1);
                        end
                    end
                    ST_FINISH: begin
                        Busy  <= 1'b0;
                        state <= ST_IDLE;
                    end
                    default: begin
                        Busy              <= 1'b0;
                        Computation_Start <= 1'b0;
                        state             <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_cgra_kernel_launcher.sv
// Self-checking bench for cgra_kernel_launcher. A CGRA responder model
// answers the handshake; each launch pushes its expected batch outcome,
// and a monitor pops and compares whenever Launch_Done pulses.
module tb_cgra_kernel_launcher;

    localparam int CW = 32;
    localparam int NW = 16;

    logic          Clk = 1'b0;
    logic          Resetn = 1'b0;
    logic          Launch_Req = 1'b0;
    logic          Abort = 1'b0;
    logic [NW-1:0] Iter_Count = '0;
    logic [CW-1:0] Timeout_Cycles = '0;
    logic          Computation_Start;
    logic          Computation_Done = 1'b0;
    logic          Busy;
    logic          Launch_Done;
    logic          Error;
    logic [NW-1:0] Iter_Done;
    logic [CW-1:0] Cycle_Count;

    cgra_kernel_launcher #(.CWIDTH(CW), .NWIDTH(NW)) dut (
        .Clk               (Clk),
        .Resetn            (Resetn),
        .Launch_Req        (Launch_Req),
        .Abort             (Abort),
        .Iter_Count        (Iter_Count),
        .Timeout_Cycles    (Timeout_Cycles),
        .Computation_Start (Computation_Start),
        .Computation_Done  (Computation_Done),
        .Busy              (Busy),
        .Launch_Done       (Launch_Done),
        .Error             (Error),
        .Iter_Done         (Iter_Done),
        .Cycle_Count       (Cycle_Count)
    );

    always #5 Clk = ~Clk;

    // Expected batch outcome; -1 in start_hi/busy means "not checked".
    typedef struct {
        int iter;
        int err;
        int starts;
        int start_hi;
        int busy;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic chk(string name, longint act, longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // CGRA responder: raise Done rise_d cycles after Start is seen high,
    // drop it fall_d cycles after Start is seen low.
    int rise_d   = 10;
    int fall_d   = 3;
    bit hang     = 1'b0;
    bit force_hi = 1'b0;
    int rc = 0;
    int fc = 0;

    always @(negedge Clk) begin
        if (force_hi) begin
            Computation_Done = 1'b1;
        end else if (hang) begin
            Computation_Done = 1'b0;
        end else if (Computation_Start) begin
            fc = 0;
            if (!Computation_Done) begin
                rc++;
                if (rc >= rise_d) begin
                    Computation_Done = 1'b1;
                    rc = 0;
                end
            end
        end else begin
            rc = 0;
            if (Computation_Done) begin
                fc++;
                if (fc >= fall_d) begin
                    Computation_Done = 1'b0;
                    fc = 0;
                end
            end
        end
    end

    // Monitor: per-batch observation counters and scoreboard compare.
    int   m_starts = 0;
    int   m_hi     = 0;
    int   m_busy   = 0;
    bit   p_busy   = 1'b0;
    bit   p_start  = 1'b0;
    bit   pend_cc  = 1'b0;
    exp_t m_e;

    always @(negedge Clk) begin
        if (!Resetn) begin
            p_busy  = 1'b0;
            p_start = 1'b0;
            pend_cc = 1'b0;
        end else begin
            if (pend_cc) begin
                chk("cycle_count", Cycle_Count, m_busy);
                chk("busy_after_done", Busy, 0);
                pend_cc = 1'b0;
            end
            if (Busy && !p_busy) begin
                m_starts = 0;
                m_hi     = 0;
                m_busy   = 0;
            end
            if (Busy) m_busy++;
            if (Computation_Start) begin
                m_hi++;
                if (!p_start) m_starts++;
            end
            p_busy  = Busy;
            p_start = Computation_Start;
            if (Launch_Done) begin
                if (sb.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL launch_done: unexpected pulse with empty scoreboard");
                end else begin
                    m_e = sb.pop_front();
                    chk("iter_done", Iter_Done, m_e.iter);
                    chk("error", Error, m_e.err);
                    chk("start_pulses", m_starts, m_e.starts);
                    if (m_e.start_hi >= 0) chk("start_high_cycles", m_hi, m_e.start_hi);
                    if (m_e.busy >= 0) chk("busy_cycles", m_busy, m_e.busy);
                    pend_cc = 1'b1;
                end
            end
        end
    end

    task automatic launch(int n, int t, exp_t e);
        sb.push_back(e);
        @(negedge Clk);
        Launch_Req     = 1'b1;
        Iter_Count     = NW'(n);
        Timeout_Cycles = CW'(t);
        @(negedge Clk);
        Launch_Req = 1'b0;
    endtask

    task automatic wait_idle(string name);
        int k = 0;
        while ((sb.size() != 0 || pend_cc) && k < 3000) begin
            @(negedge Clk);
            k++;
        end
        chk({name, "_completes"}, (k < 3000), 1);
        sb.delete();
        @(negedge Clk);
    endtask

    task automatic wait_start(logic lvl, string name);
        int k = 0;
        while (Computation_Start !== lvl && k < 500) begin
            @(negedge Clk);
            k++;
        end
        chk({name, "_reached"}, (k < 500), 1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        repeat (3) @(negedge Clk);
        chk("rst_start", Computation_Start, 0);
        chk("rst_busy", Busy, 0);
        chk("rst_launch_done", Launch_Done, 0);
        chk("rst_error", Error, 0);
        chk("rst_iter_done", Iter_Done, 0);
        chk("rst_cycle_count", Cycle_Count, 0);
        Resetn = 1'b1;
        repeat (2) @(negedge Clk);

        // Single invocation and a four-invocation batch.
        rise_d = 10; fall_d = 3;
        launch(1, 0, '{1, 0, 1, -1, -1});
        wait_idle("single");
        launch(4, 0, '{4, 0, 4, -1, -1});
        wait_idle("batch");

        // Zero count: Busy for exactly the FINISH cycle, no Start.
        launch(0, 0, '{0, 0, 0, 0, 1});
        wait_idle("zero");

        // Timeout with an unresponsive CGRA, then Error clears on relaunch.
        hang = 1'b1;
        launch(3, 20, '{0, 1, 1, 20, -1});
        wait_idle("timeout");
        hang = 1'b0;
        launch(1, 0, '{1, 0, 1, -1, -1});
        chk("error_cleared", Error, 0);
        wait_idle("after_timeout");

        // Stale Done at launch, ignored relaunch while busy, then abort.
        force_hi = 1'b1;
        repeat (4) @(negedge Clk);
        rise_d = 8; fall_d = 3;
        launch(2, 0, '{0, 1, 1, -1, -1});
        for (int i = 0; i < 6; i++) begin
            chk("stale_start_low", Computation_Start, 0);
            @(negedge Clk);
        end
        force_hi = 1'b0;
        wait_start(1'b1, "stale_rise");
        Launch_Req = 1'b1;
        Iter_Count = '0;
        @(negedge Clk);
        Launch_Req = 1'b0;
        Abort      = 1'b1;
        chk("start_held_while_busy", Computation_Start, 1);
        @(negedge Clk);
        Abort = 1'b0;
        chk("abort_start_low", Computation_Start, 0);
        chk("abort_error", Error, 1);
        wait_idle("abort");

        // Asynchronous reset in RELEASE, then a clean batch.
        rise_d = 4; fall_d = 6;
        launch(3, 0, '{3, 0, 3, -1, -1});
        wait_start(1'b1, "rr_rise");
        wait_start(1'b0, "rr_release");
        #2 Resetn = 1'b0;
        #1;
        chk("arst_start", Computation_Start, 0);
        chk("arst_busy", Busy, 0);
        chk("arst_launch_done", Launch_Done, 0);
        chk("arst_error", Error, 0);
        chk("arst_iter_done", Iter_Done, 0);
        chk("arst_cycle_count", Cycle_Count, 0);
        sb.delete();
        @(negedge Clk);
        Resetn = 1'b1;
        @(negedge Clk);
        launch(2, 0, '{2, 0, 2, -1, -1});
        wait_idle("post_reset");

        // Randomized batches with generous or disabled timeout.
        for (int i = 0; i < 8; i++) begin
            int n;
            int t;
            n = int'($urandom_range(0, 5));
            rise_d = int'($urandom_range(1, 8));
            fall_d = int'($urandom_range(1, 8));
            t = ($urandom_range(0, 1) == 0) ? 0 : 500;
            e.iter     = n;
            e.err      = 0;
            e.starts   = n;
            e.start_hi = -1;
            e.busy     = (n == 0) ? 1 : -1;
            launch(n, t, e);
            wait_idle("random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
